prco_ctrl: RTL

- One-hot sequencer for the prco core datapath.
- Steps each instruction through fetch, decode, register read, ALU, optional RAM access and register write-back.
- Issues a single-cycle clock-enable pulse to each stage, owns the program counter and the lmem address-source select, and detects halt and memory timeout.
- Replaces ad-hoc clock-enable chaining between lmem, decoder, regs and alu.

---
 rtl/prco_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/prco_ctrl.sv
// prco_ctrl: one-hot instruction sequencer for the prco core datapath.
// Latency: 6 cycles per instruction with 1-cycle-late mem ack, 8 with a RAM access.
// Backpressure: i_en=0 freezes state/PC/timeout; the mem wait is bounded by MEM_TIMEOUT.
//
// Ports:
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_en                  advance enable (0 freezes the sequencer)
//   i_mem_ack             lmem access complete (only looked at in FETCH/RAM)
//   i_dec_*               decoder flags: halt (DECODE), ram_req (EXEC), reg_we (EXEC/RAM exit)
//   i_branch_*            branch resolution, sampled on the WRITE->FETCH edge
//   q_state               one-hot state [0]RESET [1]FETCH [2]DECODE [3]READ
//                         [4]EXEC [5]RAM [6]WRITE [7]HALT
//   q_pc                  program counter
//   q_ce_*, q_reg_we      single-cycle stage enables, high in the first cycle of a state
//   q_mem_sel             lmem address source: 0 = q_pc, 1 = ALU result
//   q_fault               sticky memory-timeout flag
//   q_retired             retired-instruction count (only with PRCO_CTRL_PERF_EN)
//
// Optional feature macro: PRCO_CTRL_PERF_EN adds the q_retired counter port.

module prco_ctrl #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_en,
  input  logic        i_mem_ack,
  input  logic        i_dec_halt,
  input  logic        i_dec_ram_req,
  input  logic        i_dec_reg_we,
  input  logic        i_branch_taken,
  input  logic [15:0] i_branch_target,
  output logic [7:0]  q_state,
  output logic [15:0] q_pc,
  output logic        q_ce_fetch,
  output logic        q_ce_dec,
  output logic        q_ce_reg,
  output logic        q_ce_alu,
  output logic        q_ce_ram,
  output logic        q_reg_we,
  output logic        q_mem_sel,
  output logic        q_fault
`ifdef PRCO_CTRL_PERF_EN
  ,
  output logic [31:0] q_retired
`endif
);

  typedef enum logic [7:0] {
    S_RESET  = 8'h01,
    S_FETCH  = 8'h02,
    S_DECODE = 8'h04,
    S_READ   = 8'h08,
    S_EXEC   = 8'h10,
    S_RAM    = 8'h20,
    S_WRITE  = 8'h40,
    S_HALT   = 8'h80
  } state_t;

  // The counter holds the number of ack-less enabled cycles already spent in
  // the current wait state, so the MEM_TIMEOUT-th such cycle is the one that
  // sees TO_LAST; an ack in that same cycle is checked first and wins.
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state;
  logic [7:0] tcnt;

  assign q_state = state;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= S_RESET;
      q_pc       <= RESET_PC;
      tcnt       <= 8'd0;
      q_ce_fetch <= 1'b0;
      q_ce_dec   <= 1'b0;
      q_ce_reg   <= 1'b0;
      q_ce_alu   <= 1'b0;
      q_ce_ram   <= 1'b0;
      q_reg_we   <= 1'b0;
      q_mem_sel  <= 1'b0;
      q_fault    <= 1'b0;
`ifdef PRCO_CTRL_PERF_EN
      q_retired  <= 32'd0;
`endif
    end else begin
      // Pulses are one cycle wide regardless of i_en; they are only ever
      // raised on an enabled transition edge below.
      q_ce_fetch <= 1'b0;
      q_ce_dec   <= 1'b0;
      q_ce_reg   <= 1'b0;
      q_ce_alu   <= 1'b0;
      q_ce_ram   <= 1'b0;
      q_reg_we   <= 1'b0;

      if (i_en) begin
        unique case (state)
          S_RESET: begin
            state      <= S_FETCH;
            q_ce_fetch <= 1'b1;
            q_mem_sel  <= 1'b0;
            tcnt       <= 8'd0;
          end
          S_FETCH: begin
            if (i_mem_ack) begin
              state    <= S_DECODE;
              q_ce_dec <= 1'b1;
            end else if (tcnt == TO_LAST) begin
              state   <= S_HALT;
              q_fault <= 1'b1;
            end else begin
              tcnt <= tcnt + 8'd1;
            end
          end
          S_DECODE: begin
            if (i_dec_halt) begin
              state <= S_HALT;
            end else begin
              state    <= S_READ;
              q_ce_reg <= 1'b1;
            end
          end
          S_READ: begin
            state    <= S_EXEC;
            q_ce_alu <= 1'b1;
          end
          S_EXEC: begin
            if (i_dec_ram_req) begin
              state     <= S_RAM;
              q_ce_ram  <= 1'b1;
              q_mem_sel <= 1'b1;
              tcnt      <= 8'd0;
            end else begin
              state    <= S_WRITE;
              q_reg_we <= i_dec_reg_we;
            end
          end
          S_RAM: begin
            if (i_mem_ack) begin
              state     <= S_WRITE;
              q_reg_we  <= i_dec_reg_we;
              q_mem_sel <= 1'b0;
            end else if (tcnt == TO_LAST) begin
              // Park the address mux back on the PC once the access is abandoned.
              state     <= S_HALT;
              q_fault   <= 1'b1;
              q_mem_sel <= 1'b0;
            end else begin
              tcnt <= tcnt + 8'd1;
            end
          end
          S_WRITE: begin
            state      <= S_FETCH;
            q_ce_fetch <= 1'b1;
            tcnt       <= 8'd0;
            q_pc       <= i_branch_taken ? i_branch_target : q_pc + 16'd1;
`ifdef PRCO_CTRL_PERF_EN
            q_retired  <= q_retired + 32'd1;
`endif
          end
          S_HALT: begin
            state <= S_HALT;
          end
          default: begin
            // Unreachable for a legal one-hot value; restart cleanly.
            state <= S_RESET;
          end
        endcase
      end
    end
  end

endmodule
